// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker
// Read-side stage behind the async FIFO, running in the rclk domain. It pops
// DSIZE-bit words from the show-ahead read port and serialises each word into
// DSIZE/OSIZE lanes on a valid/ready stream. The next word is popped during the
// last-lane transfer, so word boundaries cost no bubble cycle.
//
// Build option: define FIFO_RD_MSB_FIRST_EN to emit lanes most-significant
// first. When it is undefined, lanes are emitted least-significant first.
// Timing, handshake and m_last are the same in both builds.

module fifo_rd_unpacker #(
  parameter int DSIZE = 32,
  parameter int OSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             flush,
  output logic [OSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int RATIO  = DSIZE / OSIZE;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Refuse to build a geometry that cannot be split into two or more whole lanes.
  if (((DSIZE % OSIZE) != 0) || (RATIO < 2)) begin : g_paramCheck
    $error("fifo_rd_unpacker: DSIZE must be a multiple of OSIZE with at least two lanes");
  end

  logic [DSIZE-1:0]  r_wbuf;
  logic [LANE_W-1:0] r_lane;
  logic              r_hold;

  logic              w_lastLane;
  logic              w_transfer;
  logic [OSIZE-1:0]  w_laneData;

  assign w_lastLane = (r_lane == LANE_W'(RATIO - 1));
  assign w_transfer = r_hold && m_ready;

  // The pop is requested combinationally so that a new word can be loaded on
  // the same edge that retires the last lane of the old one. Reset and flush
  // both suppress it, so nothing is taken from the FIFO while the stage is
  // being cleared.
  assign rinc = !rrst && !flush && !rempty && (!r_hold || (m_ready && w_lastLane));

  // Word register, lane index and hold flag. Flush outranks pop and transfer.
  // It keeps wbuf, because only the hold flag decides whether wbuf is visible.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_wbuf <= '0;
      r_lane <= '0;
      r_hold <= 1'b0;
    end else if (flush) begin
      r_lane <= '0;
      r_hold <= 1'b0;
    end else if (rinc) begin
      r_wbuf <= rdata;
      r_lane <= '0;
      r_hold <= 1'b1;
    end else if (w_transfer) begin
      if (w_lastLane) begin
        r_lane <= '0;
        r_hold <= 1'b0;
      end else begin
        r_lane <= r_lane + LANE_W'(1);
      end
    end
  end

  // Lane select. A compare-based mux keeps the lane index within RATIO even
  // when RATIO is not a power of two.
  always_comb begin
    w_laneData = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (r_lane == LANE_W'(i)) begin
`ifdef FIFO_RD_MSB_FIRST_EN
        w_laneData = r_wbuf[(RATIO - 1 - i) * OSIZE +: OSIZE];
`else
        w_laneData = r_wbuf[i * OSIZE +: OSIZE];
`endif
      end
    end
  end

  assign m_data  = w_laneData;
  assign m_valid = r_hold;
  assign m_last  = r_hold && w_lastLane;

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb_fifo_rd_unpacker
// Scoreboard bench for fifo_rd_unpacker. A queue-based FIFO model feeds the
// show-ahead read port. Each word that is enqueued pushes its expected lanes
// onto the scoreboard, and every observed lane transfer pops one entry and
// compares it. FIFO_RD_MSB_FIRST_EN selects the expected lane order.

module tb_fifo_rd_unpacker;

  localparam int DSIZE = 32;
  localparam int OSIZE = 8;
  localparam int RATIO = DSIZE / OSIZE;

  typedef struct {
    logic [OSIZE-1:0] data;
    logic             last;
  } lane_t;

  logic             rclk;
  logic             rrst;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             flush;
  logic [OSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  logic [DSIZE-1:0] fifoQ[$];
  lane_t            expQ[$];

  int vectorCount;
  int missCount;

  logic             sRinc;
  logic             sValid;
  logic [OSIZE-1:0] sData;
  logic             sLast;

  fifo_rd_unpacker #(
    .DSIZE(DSIZE),
    .OSIZE(OSIZE)
  ) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .rdata  (rdata),
    .rempty (rempty),
    .rinc   (rinc),
    .flush  (flush),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last)
  );

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // Hard stop in case something above hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Put a word into the FIFO model and queue its lanes in emission order.
  task automatic enqueueWord(input logic [DSIZE-1:0] w);
    lane_t item;
    int    idx;
    fifoQ.push_back(w);
    for (int i = 0; i < RATIO; i++) begin
`ifdef FIFO_RD_MSB_FIRST_EN
      idx = RATIO - 1 - i;
`else
      idx = i;
`endif
      item.data = w[idx * OSIZE +: OSIZE];
      item.last = (i == RATIO - 1);
      expQ.push_back(item);
    end
  endtask

  // Drop the remaining lanes of the word that is currently being emitted.
  task automatic discardRestOfWord();
    lane_t item;
    item.last = 1'b0;
    while (expQ.size() != 0 && !item.last) begin
      item = expQ.pop_front();
    end
  endtask

  // Run one clock cycle. Inputs are driven on the falling edge and outputs are
  // sampled 1 time unit later. Any transfer is scored against the queue, and
  // the FIFO model pops on the rising edge if rinc was high.
  task automatic applyStimulus(input logic rdy, input logic fl, input logic rs);
    lane_t item;
    logic  popNow;
    @(negedge rclk);
    m_ready = rdy;
    flush   = fl;
    rrst    = rs;
    rempty  = (fifoQ.size() == 0);
    rdata   = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    #1;
    sRinc  = rinc;
    sValid = m_valid;
    sData  = m_data;
    sLast  = m_last;
    if (rempty) checkOutput("rincWhileEmpty", {31'b0, sRinc}, 32'd0);
    if (!rs && !fl && (sValid === 1'b1) && rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousLane", {24'b0, sData}, 32'hFFFF_FFFF);
      end else begin
        item = expQ.pop_front();
        checkOutput("laneData", {24'b0, sData}, {24'b0, item.data});
        checkOutput("laneLast", {31'b0, sLast}, {31'b0, item.last});
      end
    end
    popNow = (sRinc === 1'b1);
    @(posedge rclk);
    if (popNow && fifoQ.size() != 0) void'(fifoQ.pop_front());
  endtask

  // Keep stepping until the scoreboard is empty or the cycle budget runs out.
  task automatic drain(input int budget, input bit randomReady);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus(randomReady ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drainDone", expQ.size(), 32'd0);
  endtask

  // Directed scenarios followed by a short randomized-backpressure stream.
  initial begin
    vectorCount = 0;
    missCount   = 0;
    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    rempty  = 1'b1;
    rdata   = '0;

    // Reset while a word is waiting: nothing pops until reset drops.
    enqueueWord(32'h1122_3344);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rstRinc",  {31'b0, sRinc},  32'd0);
      checkOutput("rstValid", {31'b0, sValid}, 32'd0);
      checkOutput("rstData",  {24'b0, sData},  32'd0);
      checkOutput("rstLast",  {31'b0, sLast},  32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("firstPopRinc",  {31'b0, sRinc},  32'd1);
    checkOutput("firstPopValid", {31'b0, sValid}, 32'd0);
    drain(20, 1'b0);

    // Single word with the consumer always ready.
    enqueueWord(32'hAABB_CCDD);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("singleRinc",  {31'b0, sRinc},  {31'b0, (c == 0)});
      checkOutput("singleValid", {31'b0, sValid}, {31'b0, (c >= 1 && c <= 4)});
    end
    checkOutput("singleDrained", expQ.size(), 32'd0);

    // Two queued words stream out with no gap between them.
    enqueueWord(32'h0302_0100);
    enqueueWord(32'h0706_0504);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("b2bRinc",  {31'b0, sRinc},  {31'b0, (c == 0 || c == 4)});
      checkOutput("b2bValid", {31'b0, sValid}, {31'b0, (c >= 1 && c <= 8)});
    end
    checkOutput("b2bDrained", expQ.size(), 32'd0);

    // Backpressure on lane 1 holds the output steady and blocks the next pop.
    enqueueWord(32'hAABB_CCDD);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    enqueueWord(32'h5566_7788);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stallValid", {31'b0, sValid}, 32'd1);
      checkOutput("stallData",  {24'b0, sData},  {24'b0, expQ[0].data});
      checkOutput("stallLast",  {31'b0, sLast},  32'd0);
      checkOutput("stallRinc",  {31'b0, sRinc},  32'd0);
    end
    drain(30, 1'b0);

    // Flush after lane 1 discards the last two lanes and resumes with the next word.
    enqueueWord(32'hAABB_CCDD);
    enqueueWord(32'h4433_2211);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("flushRinc", {31'b0, sRinc}, 32'd0);
    discardRestOfWord();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("postFlushValid", {31'b0, sValid}, 32'd0);
    checkOutput("postFlushRinc",  {31'b0, sRinc},  32'd1);
    drain(20, 1'b0);

    // The FIFO runs empty at the last lane, and a later word is popped on arrival.
    enqueueWord(32'h0BAD_F00D);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("emptyValid", {31'b0, sValid}, 32'd0);
      checkOutput("emptyRinc",  {31'b0, sRinc},  32'd0);
    end
    enqueueWord(32'hCAFE_1234);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("arriveRinc",  {31'b0, sRinc},  32'd1);
    checkOutput("arriveValid", {31'b0, sValid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("arriveNextValid", {31'b0, sValid}, 32'd1);
    drain(20, 1'b0);

    // Random words with random consumer stalls.
    for (int w = 0; w < 6; w++) enqueueWord($urandom);
    drain(400, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
